// File: rtl/cone_scan_driver.sv
// Serial scan driver for an extracted combinational cone: shifts a vector in, settles, captures CONE_Y.
// Optional response signature (16-bit CRC-CCITT MISR) is enabled by defining CONE_SIG_EN.
module cone_scan_driver #(
    parameter int WIDTH         = 30,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             SI,
    input  logic             CONE_Y,
    output logic [WIDTH-1:0] VEC_OUT,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE,
    output logic             RESP,
    output logic [15:0]      SIG
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, CAPTURE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] bit_cnt;
    logic [SW-1:0] set_cnt;
    logic          shift_en, settle_en, capture_en;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (ABORT) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (START) next_state = SHIFT;
                SHIFT:   if (bit_cnt == BIT_LAST) next_state = SETTLE;
                SETTLE:  if (set_cnt == SET_LAST) next_state = CAPTURE;
                CAPTURE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Abort suppresses any datapath update on the edge it is sampled.
    always_comb begin
        BUSY       = (state != IDLE);
        shift_en   = (state == SHIFT)   && !ABORT;
        settle_en  = (state == SETTLE)  && !ABORT;
        capture_en = (state == CAPTURE) && !ABORT;
    end

    // Counters run only while their phase is active and are zero on entry to it.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
            set_cnt <= '0;
        end else begin
            bit_cnt <= shift_en  ? bit_cnt + CW'(1) : '0;
            set_cnt <= settle_en ? set_cnt + SW'(1) : '0;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            VEC_OUT <= '0;
            DONE    <= 1'b0;
            RESP    <= 1'b0;
        end else begin
            if (shift_en) VEC_OUT <= {VEC_OUT[WIDTH-2:0], SI};
            DONE <= capture_en;
            if (capture_en) RESP <= CONE_Y;
        end
    end

    assign SO = VEC_OUT[WIDTH-1];

`ifdef CONE_SIG_EN
    always_ff @(posedge CK or posedge RST) begin
        if (RST) SIG <= 16'h0000;
        else if (capture_en)
            SIG <= {SIG[14:0], 1'b0} ^ ((SIG[15] ^ CONE_Y) ? 16'h1021 : 16'h0000);
    end
`else
    assign SIG = 16'h0000;
`endif

endmodule

// File: tb/tb_cone_scan_driver.sv
// Self-checking bench for cone_scan_driver: directed plan items plus randomized sequences
// checked against a transaction-level model of vector, response and signature.
module tb_cone_scan_driver;

    localparam int W = 30;
    localparam int S = 1;
    localparam int P = W + S + 2;   // START edge to DONE-high cycle, also the back-to-back period

    logic         CK, RST, START, ABORT, SI, CONE_Y;
    logic [W-1:0] VEC_OUT;
    logic         SO, BUSY, DONE, RESP;
    logic [15:0]  SIG;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    logic [W-1:0] m_vec;
    logic         m_resp;
    logic [15:0]  m_sig;

    cone_scan_driver #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .SI(SI), .CONE_Y(CONE_Y),
        .VEC_OUT(VEC_OUT), .SO(SO), .BUSY(BUSY), .DONE(DONE), .RESP(RESP), .SIG(SIG)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    function automatic logic [15:0] sig_after(input logic [15:0] s, input logic y);
`ifdef CONE_SIG_EN
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16] ^ y) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    function automatic void model_reset();
        m_vec  = '0;
        m_resp = 1'b0;
        m_sig  = 16'h0000;
    endfunction

    // One full load/settle/capture; CONE_Y carries the wanted value only on the capture edge.
    task automatic run_seq(input logic [W-1:0] vec, input logic cy);
        logic [W-1:0] so_seen;
        int  n;
        bit  seen;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        for (int i = 0; i < W; i++) begin
            so_seen[W-1-i] = SO;
            SI = vec[W-1-i];
            tick();
        end
        check("so_shift_out", so_seen, m_vec);
        check("vec_loaded", VEC_OUT, vec);
        m_vec = vec;
        n = W;
        seen = 0;
        while (!seen && n < W + S + 40) begin
            CONE_Y = (n == W + S) ? cy : ~cy;
            tick();
            n++;
            if (DONE) seen = 1;
        end
        CONE_Y = ~cy;
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            m_resp = cy;
            m_sig  = sig_after(m_sig, cy);
            check("done_latency", n + 1, P);
            check("resp", RESP, m_resp);
            check("busy_low_with_done", BUSY, 0);
            check("vec_frozen", VEC_OUT, m_vec);
            check("so_is_msb", SO, m_vec[W-1]);
            check("sig", SIG, m_sig);
            tick();
            check("done_one_cycle", DONE, 0);
        end
    endtask

    initial begin
        logic [W-1:0] v, bits;
        logic         cy;
        int           pulses, first, last, gap_bad;
        bit           done_seen;

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; SI = 1'b0; CONE_Y = 1'b0;
        model_reset();
        #12;
        check("rst_vec", VEC_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_sig", SIG, 0);
        tick();
        RST = 1'b0;
        tick();

        // Reset mid-shift: load a nonzero vector first, then reset 10 bits into the next load.
        run_seq(30'h1234ABCD, 1'b1);
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 10; i++) begin SI = 1'b1; tick(); end
        RST = 1'b1;
        #2;
        check("amid_rst_vec", VEC_OUT, 0);
        check("amid_rst_busy", BUSY, 0);
        check("amid_rst_done", DONE, 0);
        check("amid_rst_resp", RESP, 0);
        check("amid_rst_so", SO, 0);
        check("amid_rst_sig", SIG, 0);
        tick();
        RST = 1'b0;
        model_reset();
        tick();

        // Directed load/capture, signature sequence, and all-ones shift-out.
        run_seq(30'h2AAAAAAA, 1'b1);
`ifdef CONE_SIG_EN
        check("sig_first", SIG, 16'h1021);
`else
        check("sig_off_first", SIG, 16'h0000);
`endif
        run_seq(30'h3FFFFFFF, 1'b0);
`ifdef CONE_SIG_EN
        check("sig_second", SIG, 16'h2042);
`else
        check("sig_off_second", SIG, 16'h0000);
`endif
        run_seq(30'h00000000, 1'b1);

        // Randomized sequences with random idle gaps.
        for (int k = 0; k < 8; k++) begin
            v  = W'($urandom);
            cy = 1'($urandom);
            run_seq(v, cy);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        // Back-to-back: START held high for three full sequences.
        cy = 1'($urandom);
        CONE_Y = cy;
        START = 1'b1;
        pulses = 0; first = -1; last = -1; gap_bad = 0;
        for (int n = 0; n < 3 * P; n++) begin
            SI = 1'($urandom);
            if ((n % P) >= 1 && (n % P) <= W) m_vec = {m_vec[W-2:0], SI};
            tick();
            if (DONE) begin
                if (first < 0) first = n;
                else if (n - last != P) gap_bad++;
                last = n;
                pulses++;
                m_sig = sig_after(m_sig, cy);
            end
        end
        START = 1'b0;
        m_resp = cy;
        check("b2b_pulses", pulses, 3);
        check("b2b_first", first, P - 1);
        check("b2b_spacing", gap_bad, 0);
        check("b2b_vec", VEC_OUT, m_vec);
        check("b2b_resp", RESP, m_resp);
        check("b2b_sig", SIG, m_sig);
        tick();
        check("b2b_idle", BUSY, 0);

        // Abort after 15 shifts: partial vector kept, no DONE, RESP/SIG untouched.
        bits = W'($urandom);
        CONE_Y = ~m_resp;
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 15; i++) begin SI = bits[i]; tick(); end
        for (int i = 0; i < 15; i++) m_vec = {m_vec[W-2:0], bits[i]};
        ABORT = 1'b1; SI = 1'($urandom); tick(); ABORT = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_vec", VEC_OUT, m_vec);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (DONE) done_seen = 1; end
        check("abort_no_done", done_seen, 0);
        check("abort_resp", RESP, m_resp);
        check("abort_sig", SIG, m_sig);

        // Abort during SETTLE: full vector loaded, capture suppressed.
        v = W'($urandom);
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < W; i++) begin SI = v[W-1-i]; tick(); end
        m_vec = v;
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        done_seen = DONE;
        for (int i = 0; i < 5; i++) begin tick(); if (DONE) done_seen = 1; end
        check("abort_settle_busy", BUSY, 0);
        check("abort_settle_no_done", done_seen, 0);
        check("abort_settle_vec", VEC_OUT, m_vec);
        check("abort_settle_resp", RESP, m_resp);

        // A normal sequence still works after aborts.
        run_seq(W'($urandom), ~m_resp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
